i4004_timing: RTL and testbench
===============================

Name: i4004_timing

Overview:
- Machine-cycle sequencer for the i4004 core. Runs from the design clock `clk_i`.
- Synchronizes the external PHI2_i clock phase and advances an 8-state cycle: A1 A2 A3 M1 M2 X1 X2 X3.
- Generates SYNC, CM-ROM/CM-RAM strobes, data-bus direction and latch enables, and tracks two-word instructions and the chip RESET_i sequence.
- Sits between the pin-level i4004 top and its datapath/PC stack.

Parameters:
- SYNC_STAGES, 2, flops in the PHI2_i synchronizer (min 2).
- RESET_STEPS, 64, minimum number of phase steps RESET_i must be held before a clean restart is signalled.

Ports:
- clk_i  in  1  design clock.
- rst_ni  in  1  asynchronous active-low reset.
- phi2_i  in  1  raw PHI2 pin, asynchronous to clk_i.
- reset_pin_i  in  1  chip RESET_i pin, active-high, already synchronous to clk_i.
- two_word_i  in  1  decoder: opcode latched at M1/M2 is a two-word instruction (FIN, JCN, ISZ, JUN, JMS, FIM).
- io_inst_i  in  1  decoder: current instruction is an I/O/RAM group (opr 0xE).
- src_i  in  1  decoder: current instruction is SRC.
- ram_bank_i  in  4  one-hot CM-RAM select from the DCL register.
- step_o  out  1  one-clock pulse on each state advance.
- state_o  out  3  current state, A1=0 … X3=7.
- sync_o  out  1  SYNC, active-high internally; the top inverts it.
- cm_rom_o  out  1  CM-ROM strobe.
- cm_ram_o  out  4  CM-RAM strobes.
- bus_oe_o  out  1  core drives D_io.
- addr_nib_o  out  2  PC nibble to drive: 0/1/2 in A1/A2/A3.
- opr_le_o  out  1  latch high opcode nibble (M1).
- opa_le_o  out  1  latch low opcode nibble (M2).
- second_word_o  out  1  current cycle fetches the second word of a two-word instruction.
- pc_inc_o  out  1  one-clock pulse: increment PC.
- clear_o  out  1  core register clear while reset is in progress.

Behaviour:
- rst_ni low, asynchronous. All outputs 0 except clear_o=1. State=X3, synchronizer cleared, step counter 0.
- Synchronizer: phi2_i passes through SYNC_STAGES flops, then an edge register. A rising edge at the synchronizer output produces step_o=1 for exactly one clk_i. Latency from a phi2_i rise to step_o is SYNC_STAGES+1 clocks. A PHI2 high time shorter than one clk_i may be missed; that is legal and not flagged.
- On step_o, state advances A1→A2→…→X3→A1 and wraps with no skip. Between steps, state and all level outputs hold.
- Level outputs, registered and updated on the step clock:
  - sync_o=1 in X3.
  - addr_nib_o=state in A1..A3, else 0.
  - bus_oe_o=1 in A1, A2, A3; also 1 in X2 and X3 when src_i is set.
  - cm_rom_o=1 in A3. Also 1 in M2 when io_inst_i is set and second_word_o=0. Also 1 in X2 when src_i is set.
  - cm_ram_o=ram_bank_i under the same three conditions, else 0.
- Pulses (one clk_i, coincident with the step that enters the state):
  - opr_le_o on entering M1.
  - opa_le_o on entering M2.
  - pc_inc_o on entering M1.
- Two-word tracking: two_word_i is sampled on the step into X1. If 1 and second_word_o=0, second_word_o is set on the step into A1 of the next cycle and cleared on the step into A1 after that. During a second word, the opcode decode inputs are ignored for the io/src qualifiers; two_word_i is not re-armed.
- Reset sequence: while reset_pin_i=1:
  - clear_o=1, state forced to A1 on each step, second_word_o=0, cm_* and bus_oe_o=0.
  - sync_o stays 0, and the step counter increments, saturating at RESET_STEPS.
  - On release with count≥RESET_STEPS, clear_o drops on the next step and normal sequencing resumes from A1.
  - On release with count<RESET_STEPS, clear_o stays 1 until the count reaches RESET_STEPS on subsequent steps, then resumes from A1.
- Simultaneous events: reset_pin_i takes priority over the step advance. Asserting rst_ni mid-cycle aborts immediately with no partial strobes.

Test Plan:
- rst_ni pulse, then 16 phi2 periods with reset_pin_i=0 and clear already satisfied (RESET_STEPS=2) → state_o 0..7,0..7; sync_o high only in state 7; opr_le_o/opa_le_o/pc_inc_o one pulse each per cycle at entry to states 3, 4, 3.
- Measure latency with SYNC_STAGES=2 → step_o exactly 3 clocks after phi2_i rises; a phi2 rise of 1 clock width still produces a single step.
- ram_bank_i=4'b0100, io_inst_i=1 → cm_rom_o=1 and cm_ram_o=4'b0100 in A3 and M2, 0 elsewhere; with src_i=1 also in X2, and bus_oe_o=1 in X2/X3.
- two_word_i=1 during the first cycle → second_word_o=1 for exactly the next 8 states; M2 with io_inst_i=1 during the second word → no cm_rom_o.
- reset_pin_i high for 10 steps with RESET_STEPS=64 → clear_o stays 1 for 54 more steps after release, then state_o=0 with sync_o=0 until state 7.
- rst_ni asserted in state 5 with second_word_o=1 → all outputs reset in the same clock, no residual strobe.

Source files
------------

// File: rtl/i4004_timing.sv
// i4004 machine-cycle sequencer: synchronizes PHI2, steps A1..X3, and drives
// SYNC, CM strobes, bus direction, opcode latch enables and the RESET_i sequence.
module i4004_timing #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_STEPS = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       phi2_i,
  input  logic       reset_pin_i,
  input  logic       two_word_i,
  input  logic       io_inst_i,
  input  logic       src_i,
  input  logic [3:0] ram_bank_i,
  output logic       step_o,
  output logic [2:0] state_o,
  output logic       sync_o,
  output logic       cm_rom_o,
  output logic [3:0] cm_ram_o,
  output logic       bus_oe_o,
  output logic [1:0] addr_nib_o,
  output logic       opr_le_o,
  output logic       opa_le_o,
  output logic       second_word_o,
  output logic       pc_inc_o,
  output logic       clear_o
);

  localparam int unsigned CNT_W = $clog2(RESET_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_STEPS);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } state_t;

  // PHI2 synchronizer and rising-edge detect
  logic [SYNC_STAGES-1:0] meta_q;
  logic                   phi_d_q;
  logic                   rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= '0;
      phi_d_q <= 1'b0;
    end else begin
      meta_q  <= {meta_q[SYNC_STAGES-2:0], phi2_i};
      phi_d_q <= meta_q[SYNC_STAGES-1];
    end
  end

  assign rise = meta_q[SYNC_STAGES-1] & ~phi_d_q;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             clear_q, clear_n;
  logic             armed_q, armed_n;
  logic             sw_q, sw_n;
  logic             step_q;
  logic             sync_q, sync_n;
  logic             rom_q, rom_n;
  logic [3:0]       ram_q, ram_n;
  logic             boe_q, boe_n;
  logic [1:0]       addr_q, addr_n;
  logic             opr_q, opr_n;
  logic             opa_q, opa_n;
  logic             pc_q, pc_n;
  logic             io_ok, src_ok, strobe;

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= X3;
      cnt_q   <= '0;
      clear_q <= 1'b1;
      armed_q <= 1'b0;
      sw_q    <= 1'b0;
      step_q  <= 1'b0;
      sync_q  <= 1'b0;
      rom_q   <= 1'b0;
      ram_q   <= 4'd0;
      boe_q   <= 1'b0;
      addr_q  <= 2'd0;
      opr_q   <= 1'b0;
      opa_q   <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      clear_q <= clear_n;
      armed_q <= armed_n;
      sw_q    <= sw_n;
      step_q  <= rise;
      sync_q  <= sync_n;
      rom_q   <= rom_n;
      ram_q   <= ram_n;
      boe_q   <= boe_n;
      addr_q  <= addr_n;
      opr_q   <= opr_n;
      opa_q   <= opa_n;
      pc_q    <= pc_n;
    end
  end

  // Next state: reset pin beats the step; clear holds A1 until the count is met
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    clear_n = clear_q;
    armed_n = armed_q;
    sw_n    = sw_q;
    if (reset_pin_i) begin
      clear_n = 1'b1;
      sw_n    = 1'b0;
      armed_n = 1'b0;
      if (rise) begin
        state_n = A1;
        if (cnt_q < CNT_MAX) cnt_n = cnt_q + CNT_W'(1);
      end
    end else if (clear_q) begin
      if (rise) begin
        state_n = A1;
        if (cnt_q >= CNT_MAX) begin
          clear_n = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
    end else if (rise) begin
      state_n = state_t'(state_q + 3'd1);
      if (state_n == X1) armed_n = two_word_i & ~sw_q;
      if (state_n == A1) begin
        sw_n    = armed_q;
        armed_n = 1'b0;
      end
    end
  end

  // Output decode for the state being entered; levels hold between steps
  always_comb begin
    sync_n = sync_q;
    rom_n  = rom_q;
    ram_n  = ram_q;
    boe_n  = boe_q;
    addr_n = addr_q;
    opr_n  = 1'b0;
    opa_n  = 1'b0;
    pc_n   = 1'b0;
    io_ok  = io_inst_i & ~sw_n;
    src_ok = src_i & ~sw_n;
    strobe = 1'b0;
    if (clear_n) begin
      sync_n = 1'b0;
      rom_n  = 1'b0;
      ram_n  = 4'd0;
      boe_n  = 1'b0;
      addr_n = 2'd0;
    end else if (rise) begin
      strobe = (state_n == A3) | (io_ok & (state_n == M2)) | (src_ok & (state_n == X2));
      sync_n = (state_n == X3);
      addr_n = (state_n <= A3) ? 2'(state_n) : 2'd0;
      boe_n  = (state_n <= A3) | (src_ok & ((state_n == X2) | (state_n == X3)));
      rom_n  = strobe;
      ram_n  = strobe ? ram_bank_i : 4'd0;
      opr_n  = (state_n == M1);
      opa_n  = (state_n == M2);
      pc_n   = (state_n == M1);
    end
  end

  assign step_o        = step_q;
  assign state_o       = state_q;
  assign sync_o        = sync_q;
  assign cm_rom_o      = rom_q;
  assign cm_ram_o      = ram_q;
  assign bus_oe_o      = boe_q;
  assign addr_nib_o    = addr_q;
  assign opr_le_o      = opr_q;
  assign opa_le_o      = opa_q;
  assign second_word_o = sw_q;
  assign pc_inc_o      = pc_q;
  assign clear_o       = clear_q;

endmodule

// File: tb/tb_i4004_timing.sv
// Directed bench for i4004_timing: step latency, cycle decode, strobes,
// two-word tracking, RESET_i sequence and asynchronous reset abort.
module tb_i4004_timing;

  // Per-state expectation tables, bit index = state (A1=0 .. X3=7)
  localparam logic [7:0] SYNC_TAB = 8'h80;
  localparam logic [7:0] OPR_TAB  = 8'h08;
  localparam logic [7:0] OPA_TAB  = 8'h10;
  localparam logic [7:0] PC_TAB   = 8'h08;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phi2 = 1'b0;
  logic       reset_pin = 1'b0;
  logic       two_word = 1'b0;
  logic       io_inst = 1'b0;
  logic       src = 1'b0;
  logic [3:0] ram_bank = 4'b0100;
  logic       step, sync, cm_rom, bus_oe, opr_le, opa_le, second_word, pc_inc, clear;
  logic [2:0] state;
  logic [3:0] cm_ram;
  logic [1:0] addr_nib;

  int n_vec = 0;
  int n_err = 0;
  int n_step = 0;

  logic [2:0] exp_st;
  logic [2:0] c_st;
  logic [3:0] c_ram;
  logic [1:0] c_addr;
  logic       c_sync, c_rom, c_boe, c_opr, c_opa, c_pc, c_sw, c_clr, got, post_pulse;
  int         lat, extra;

  i4004_timing #(.SYNC_STAGES(2), .RESET_STEPS(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .phi2_i(phi2), .reset_pin_i(reset_pin),
    .two_word_i(two_word), .io_inst_i(io_inst), .src_i(src), .ram_bank_i(ram_bank),
    .step_o(step), .state_o(state), .sync_o(sync), .cm_rom_o(cm_rom), .cm_ram_o(cm_ram),
    .bus_oe_o(bus_oe), .addr_nib_o(addr_nib), .opr_le_o(opr_le), .opa_le_o(opa_le),
    .second_word_o(second_word), .pc_inc_o(pc_inc), .clear_o(clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", tag, n_step, obs, exp);
    end
  endtask

  // One PHI2 period: high for hi clocks, then low; captures outputs on the step pulse
  task automatic do_step(input int hi);
    int n;
    n = 0; got = 1'b0; extra = 0; lat = 0; post_pulse = 1'b0;
    phi2 = 1'b1;
    n_step++;
    while (n < 16) begin
      @(posedge clk); #1;
      n++;
      if (n >= hi) phi2 = 1'b0;
      if (got && n == lat + 1) post_pulse = step | opr_le | opa_le | pc_inc;
      if (step) begin
        if (!got) begin
          got = 1'b1; lat = n;
          c_st = state; c_sync = sync; c_rom = cm_rom; c_ram = cm_ram; c_boe = bus_oe;
          c_addr = addr_nib; c_opr = opr_le; c_opa = opa_le; c_pc = pc_inc;
          c_sw = second_word; c_clr = clear;
        end else begin
          extra++;
        end
      end
      if (got && n >= hi + 4 && n >= lat + 2) break;
    end
    phi2 = 1'b0;
    check("step_seen", 32'(got), 32'd1);
  endtask

  task automatic run_steps(input int n, input logic [7:0] strb, input logic [7:0] boe,
                           input logic sw);
    for (int i = 0; i < n; i++) begin
      do_step(4);
      exp_st = exp_st + 3'd1;
      check("state", 32'(c_st), 32'(exp_st));
      check("sync", 32'(c_sync), 32'(SYNC_TAB[exp_st]));
      check("addr_nib", 32'(c_addr), (exp_st <= 3'd2) ? 32'(exp_st) : 32'd0);
      check("bus_oe", 32'(c_boe), 32'(boe[exp_st]));
      check("cm_rom", 32'(c_rom), 32'(strb[exp_st]));
      check("cm_ram", 32'(c_ram), strb[exp_st] ? 32'(ram_bank) : 32'd0);
      check("opr_le", 32'(c_opr), 32'(OPR_TAB[exp_st]));
      check("opa_le", 32'(c_opa), 32'(OPA_TAB[exp_st]));
      check("pc_inc", 32'(c_pc), 32'(PC_TAB[exp_st]));
      check("second_word", 32'(c_sw), 32'(sw));
      check("clear", 32'(c_clr), 32'd0);
      check("pulse_width", 32'(post_pulse), 32'd0);
    end
  endtask

  task automatic clear_steps(input int n);
    for (int i = 0; i < n; i++) begin
      do_step(4);
      check("clr_state", 32'(c_st), 32'd0);
      check("clr_clear", 32'(c_clr), 32'd1);
      check("clr_sync", 32'(c_sync), 32'd0);
      check("clr_second", 32'(c_sw), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd7);
    check("rst_clear", 32'(clear), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_bus_oe", 32'(bus_oe), 32'd0);
    check("rst_cm_rom", 32'(cm_rom), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Post-reset clear wait: 64 counted steps, drop on the 65th
    do_step(4);
    check("latency", 32'(lat), 32'd3);
    check("clr_state", 32'(c_st), 32'd0);
    do_step(1);
    check("latency_short", 32'(lat), 32'd3);
    check("single_step", 32'(extra), 32'd0);
    clear_steps(62);

    exp_st = 3'd7;
    run_steps(16, 8'h04, 8'h07, 1'b0);

    io_inst = 1'b1;
    run_steps(8, 8'h14, 8'h07, 1'b0);
    src = 1'b1;
    run_steps(8, 8'h54, 8'hC7, 1'b0);

    // RESET_i held for 10 steps, then 54 counting steps before clear drops
    reset_pin = 1'b1;
    @(posedge clk); #1;
    check("rp_clear", 32'(clear), 32'd1);
    check("rp_bus_oe", 32'(bus_oe), 32'd0);
    check("rp_sync", 32'(sync), 32'd0);
    check("rp_cm_ram", 32'(cm_ram), 32'd0);
    clear_steps(10);
    reset_pin = 1'b0;
    clear_steps(54);
    exp_st = 3'd7;
    run_steps(8, 8'h54, 8'hC7, 1'b0);

    // Two-word: second word ignores io qualifier and does not re-arm
    src = 1'b0;
    two_word = 1'b1;
    run_steps(8, 8'h14, 8'h07, 1'b0);
    run_steps(8, 8'h04, 8'h07, 1'b1);
    run_steps(8, 8'h14, 8'h07, 1'b0);
    run_steps(6, 8'h04, 8'h07, 1'b1);
    two_word = 1'b0;

    // Asynchronous abort in X1 of a second word
    @(posedge clk); #2;
    check("pre_abort_state", 32'(state), 32'd5);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd7);
    check("abort_second", 32'(second_word), 32'd0);
    check("abort_clear", 32'(clear), 32'd1);
    check("abort_bus_oe", 32'(bus_oe), 32'd0);
    check("abort_cm_ram", 32'(cm_ram), 32'd0);
    check("abort_addr", 32'(addr_nib), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_cm_rom", 32'(cm_rom), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_step(4);
    check("restart_state", 32'(c_st), 32'd0);
    check("restart_clear", 32'(c_clr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
